// File: rtl/spi_minion_frontend.sv
// SPI mode-0 minion front end: pad synchronisers, fixed-length frame deframer,
// push FIFO toward the fabric and a one-word holding register returned on miso.
module spi_minion_frontend #(
   parameter int unsigned BW    = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          cs_i,
   input  logic          sclk_i,
   input  logic          mosi_i,
   output logic          miso_o,
   output logic [BW-1:0] recv_msg_o,
   output logic          recv_val_o,
   input  logic          recv_rdy_i,
   input  logic [BW-1:0] send_msg_i,
   input  logic          send_val_i,
   output logic          send_rdy_o,
   output logic          minion_parity_o,
   output logic          frame_err_o
);

   localparam int unsigned FW = BW + 2;
   localparam int unsigned CW = $clog2(BW + 4);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CntFull = CW'(FW);
   localparam logic [CW-1:0] CntSat  = CW'(FW + 1);
   localparam logic [PW:0]   FifoMax = (PW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   logic [2:0] cs_q, sclk_q;
   logic [1:0] mosi_q;
   logic       cs_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cs_q   <= 3'b111;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         cs_q   <= {cs_q[1:0], cs_i};
         sclk_q <= {sclk_q[1:0], sclk_i};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign cs_s      = cs_q[1];
   assign mosi_s    = mosi_q[1];
   assign cs_fall   = cs_q[2] & ~cs_q[1];
   assign cs_rise   = ~cs_q[2] & cs_q[1];
   assign sclk_rise = ~sclk_q[2] & sclk_q[1] & ~cs_s;
   assign sclk_fall = sclk_q[2] & ~sclk_q[1] & ~cs_s;

   state_e          state_q;
   logic [FW-1:0]   rx_q;
   logic [FW-2:0]   tx_q;
   logic [CW-1:0]   bit_cnt_q;
   logic            miso_q, snap_avail_q, frame_err_q;
   logic            hold_full_q, par_q;
   logic [BW-1:0]   hold_q;
   logic [BW-1:0]   mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PW:0]     cnt_q, cnt_d;
   logic            fifo_full, frame_ok, push, pop, commit_pull;

   assign fifo_full   = (cnt_q == FifoMax);
   assign frame_ok    = (state_q == StDone) && (bit_cnt_q == CntFull);
   assign pop         = recv_val_o & recv_rdy_i;
   // A full FIFO still accepts a commit when the head is popped in the same cycle.
   assign push        = frame_ok & rx_q[FW-1] & (~fifo_full | pop);
   assign commit_pull = frame_ok & rx_q[FW-2] & snap_avail_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         rx_q         <= '0;
         tx_q         <= '0;
         bit_cnt_q    <= '0;
         miso_q       <= 1'b0;
         snap_avail_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cs_fall) begin
                  miso_q       <= hold_full_q;
                  tx_q         <= {~fifo_full, hold_full_q ? hold_q : '0};
                  snap_avail_q <= hold_full_q;
                  bit_cnt_q    <= '0;
                  state_q      <= StShift;
               end
            end
            StShift: begin
               if (sclk_rise) begin
                  rx_q <= {rx_q[FW-2:0], mosi_s};
                  if (bit_cnt_q != CntSat) bit_cnt_q <= bit_cnt_q + CW'(1);
               end
               if (sclk_fall) begin
                  miso_q <= tx_q[FW-2];
                  tx_q   <= {tx_q[FW-3:0], 1'b0};
               end
               if (cs_rise) state_q <= StDone;
            end
            StDone: begin
               frame_err_q <= (bit_cnt_q != CntFull);
               miso_q      <= 1'b0;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
         2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         par_q    <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (push) begin
            mem_q[wr_ptr_q] <= rx_q[BW-1:0];
            wr_ptr_q        <= wr_ptr_q + PW'(1);
            par_q           <= ^rx_q[BW-1:0];
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Clear and capture are exclusive: a clear needs a full register, which blocks capture.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         hold_full_q <= 1'b0;
         hold_q      <= '0;
      end else if (commit_pull) begin
         hold_full_q <= 1'b0;
      end else if (send_val_i && !hold_full_q) begin
         hold_full_q <= 1'b1;
         hold_q      <= send_msg_i;
      end
   end

   assign miso_o          = miso_q;
   assign recv_msg_o      = mem_q[rd_ptr_q];
   assign recv_val_o      = (cnt_q != '0);
   assign send_rdy_o      = ~hold_full_q;
   assign minion_parity_o = par_q;
   assign frame_err_o     = frame_err_q;

endmodule

// File: tb/tb_spi_minion_frontend.sv
// Self-checking bench: directed frames plus randomized traffic against a queue-based
// model of the push FIFO, holding register and frame commit rules.
module tb_spi_minion_frontend;
   localparam int unsigned BW    = 8;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned FW    = BW + 2;

   logic          clk, reset, cs, sclk, mosi, miso;
   logic [BW-1:0] recv_msg, send_msg;
   logic          recv_val, recv_rdy, send_val, send_rdy, par, frame_err;

   spi_minion_frontend #(.BW(BW), .DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .cs_i           (cs),
      .sclk_i         (sclk),
      .mosi_i         (mosi),
      .miso_o         (miso),
      .recv_msg_o     (recv_msg),
      .recv_val_o     (recv_val),
      .recv_rdy_i     (recv_rdy),
      .send_msg_i     (send_msg),
      .send_val_i     (send_val),
      .send_rdy_o     (send_rdy),
      .minion_parity_o(par),
      .frame_err_o    (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int err_pulses = 0;
   bit chk_en = 0;

   // Model state: FIFO contents, holding register, last accepted parity.
   logic [BW-1:0] mq[$];
   logic          m_full = 1'b0;
   logic [BW-1:0] m_hold = '0;
   logic          m_par = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      if (chk_en && !reset) begin
         if (recv_rdy && mq.size() > 0) void'(mq.pop_front());
         if (send_val && !m_full) begin
            m_full = 1'b1;
            m_hold = send_msg;
         end
      end
   end

   always @(negedge clk) begin
      if (frame_err === 1'b1) err_pulses++;
      if (chk_en && !reset) begin
         check("recv_val", recv_val, mq.size() != 0);
         if (mq.size() != 0) check("recv_msg", recv_msg, mq[0]);
         check("send_rdy", send_rdy, !m_full);
         check("parity", par, m_par);
         check("frame_err", frame_err, 0);
      end
   end

   task automatic check_reset_vals();
      check("rst_miso", miso, 0);
      check("rst_recv_val", recv_val, 0);
      check("rst_send_rdy", send_rdy, 1);
      check("rst_parity", par, 0);
      check("rst_frame_err", frame_err, 0);
   endtask

   task automatic do_frame(input logic [FW-1:0] word, input int nbits,
                           output logic [FW-1:0] mw);
      logic [FW-1:0] exp_tx, got;
      logic          snap;
      int            e0;
      recv_rdy = 1'b0;
      send_val = 1'b0;
      tick(1);
      exp_tx = {m_full, mq.size() < DEPTH, m_full ? m_hold : 8'h00};
      snap   = m_full;
      got    = '0;
      cs     = 1'b0;
      tick(8);
      for (int i = 0; i < nbits; i++) begin
         mosi = (i < int'(FW)) ? word[FW-1-i] : 1'($urandom);
         tick(8);
         sclk = 1'b1;
         got  = {got[FW-2:0], miso};
         tick(8);
         sclk = 1'b0;
      end
      tick(8);
      chk_en = 0;
      cs     = 1'b1;
      e0     = err_pulses;
      tick(10);
      check("frame_err_pulses", err_pulses - e0, (nbits != int'(FW)) ? 1 : 0);
      if (nbits == int'(FW)) begin
         check("miso_frame", got, exp_tx);
         if (word[FW-1] && mq.size() < DEPTH) begin
            mq.push_back(word[BW-1:0]);
            m_par = ^word[BW-1:0];
         end
         if (word[FW-2] && snap) m_full = 1'b0;
      end
      mw     = got;
      chk_en = 1;
   endtask

   logic [FW-1:0] mw;
   int            nb_tab[8] = '{10, 10, 10, 10, 7, 11, 3, 26};

   initial begin
      reset = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      recv_rdy = 1'b0; send_val = 1'b0; send_msg = '0;
      #1 reset = 1'b1;
      #2 check_reset_vals();
      tick(3);
      reset = 1'b0;
      tick(4);
      chk_en = 1;

      // Push 0xA5: parity of 1010_0101 is 0.
      do_frame({2'b10, 8'hA5}, 10, mw);
      check("a5_msg", recv_msg, 8'hA5);
      check("a5_val", recv_val, 1);
      check("a5_par", par, 0);
      check("a5_miso", mw, 10'h100);

      // Pull 0x3C from the holding register.
      send_msg = 8'h3C; send_val = 1'b1;
      tick(1);
      send_val = 1'b0;
      check("hold_full_rdy", send_rdy, 0);
      do_frame({2'b01, 8'h00}, 10, mw);
      check("pull_miso", mw, 10'h33C);
      check("pull_rdy", send_rdy, 1);

      recv_rdy = 1'b1;
      tick(3);
      recv_rdy = 1'b0;

      // Overflow: third push sees no space and is dropped.
      do_frame({2'b10, 8'h01}, 10, mw);
      do_frame({2'b10, 8'h02}, 10, mw);
      do_frame({2'b10, 8'h03}, 10, mw);
      check("full_miso", mw, 10'h000);
      check("ovf_head0", recv_msg, 8'h01);
      recv_rdy = 1'b1;
      tick(1);
      check("ovf_head1", recv_msg, 8'h02);
      tick(1);
      recv_rdy = 1'b0;
      check("ovf_empty", recv_val, 0);

      // Short frame: error pulse, no state change.
      send_msg = 8'h77; send_val = 1'b1;
      tick(1);
      send_val = 1'b0;
      do_frame({2'b10, 8'h11}, 10, mw);
      do_frame({2'b11, 8'h55}, 7, mw);
      check("short_head", recv_msg, 8'h11);
      check("short_hold", send_rdy, 0);

      // Reset in the middle of bit 5.
      chk_en = 0;
      recv_rdy = 1'b0; send_val = 1'b0;
      cs = 1'b0;
      tick(8);
      for (int i = 0; i < 5; i++) begin
         mosi = 1'b1; tick(8); sclk = 1'b1; tick(8); sclk = 1'b0;
      end
      #2 reset = 1'b1;
      #1 check_reset_vals();
      mq.delete(); m_full = 1'b0; m_par = 1'b0;
      cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tick(5);
      reset = 1'b0;
      tick(2);
      chk_en = 1;
      do_frame({2'b10, 8'h07}, 10, mw);
      check("post_rst_msg", recv_msg, 8'h07);
      check("post_rst_par", par, 1);

      for (int f = 0; f < 40; f++) begin
         int idle;
         idle = $urandom_range(5, 30);
         for (int c = 0; c < idle; c++) begin
            recv_rdy = 1'($urandom);
            send_val = 1'($urandom);
            send_msg = 8'($urandom);
            tick(1);
         end
         do_frame(10'($urandom), nb_tab[$urandom_range(0, 7)], mw);
      end
      tick(5);
      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
